// File: rtl/serial_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mag_comp
//  Purpose  : Bit-serial WIDTH-bit magnitude comparator. Operands are
//             scanned MSB-first, one bit per clock, behind a start/busy/done
//             handshake. Supports unsigned or two's-complement compare,
//             selected per request. Produces registered, mutually exclusive
//             A_gt_B / A_lt_B / A_eq_B flags that are held until the next
//             accepted request or reset.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand width in bits (2..64)
//  Ports
//    clk        in   rising-edge clock
//    rst        in   synchronous reset, active-high
//    start      in   request, accepted only when busy==0
//    is_signed  in   1 = two's-complement compare, 0 = unsigned
//    A, B       in   operands, sampled at accept
//    busy       out  compare in progress
//    done       out  one-cycle pulse, result flags valid
//    A_gt_B     out  A > B (held)
//    A_lt_B     out  A < B (held)
//    A_eq_B     out  A == B (held)
//  Build option
//    SERIAL_MAG_COMP_EARLY_EXIT_EN  when defined, the scan stops at the first
//    differing bit; otherwise the compare always takes WIDTH scan cycles.
// ============================================================================
module serial_mag_comp #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             A_gt_B,
    output logic             A_lt_B,
    output logic             A_eq_B
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    logic w_bit_a;
    logic w_bit_b;
    logic w_diff;
    logic w_msb;
    logic w_lsb;
    logic w_inv;
    logic w_finish;

    assign w_bit_a = a_q[idx_q];
    assign w_bit_b = b_q[idx_q];
    assign w_diff  = w_bit_a ^ w_bit_b;
    assign w_msb   = (idx_q == IDX_MSB);
    assign w_lsb   = (idx_q == '0);
    // In a signed compare the sign bit carries negative weight, so a 1 there
    // makes the operand smaller: the roles of a and b swap at the MSB only.
    assign w_inv   = sgn_q & w_msb;

`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
    assign w_finish = w_lsb | w_diff;
`else
    // Fixed latency keeps the compare time independent of the data.
    assign w_finish = w_lsb;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        eq_d      = eq_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    a_d       = A;
                    b_d       = B;
                    sgn_d     = is_signed;
                    idx_d     = IDX_MSB;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    lt_d      = 1'b0;
                    eq_d      = 1'b0;
                end else begin
                    // DONE lasts one cycle, which makes done a single pulse.
                    state_d = ST_IDLE;
                end
            end

            ST_SCAN: begin
                // Only the first differing bit may set a flag.
                if (!decided_q && w_diff) begin
                    decided_d = 1'b1;
                    gt_d      = w_inv ? w_bit_b : w_bit_a;
                    lt_d      = w_inv ? w_bit_a : w_bit_b;
                end
                if (w_finish) begin
                    state_d = ST_DONE;
                    if (!decided_q && !w_diff) begin
                        eq_d = 1'b1;
                    end
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sgn_q     <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            eq_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_q     <= sgn_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
        end
    end

    assign busy   = (state_q == ST_SCAN);
    assign done   = (state_q == ST_DONE);
    assign A_gt_B = gt_q;
    assign A_lt_B = lt_q;
    assign A_eq_B = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_comp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_mag_comp
//  Purpose  : Self-checking bench for serial_mag_comp (WIDTH=8). Requests
//             are issued by a driver that pushes the expected flags and done
//             cycle into a queue; an independent monitor pops and compares
//             every done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_serial_mag_comp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, A_gt_B, A_lt_B, A_eq_B;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] flags;     // {gt, lt, eq}
        int         done_cyc;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] last_flags = 3'b000;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .A_gt_B    (A_gt_B),
        .A_lt_B    (A_lt_B),
        .A_eq_B    (A_eq_B)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: numeric compare of the operands as integers, plus the
    // position of the most significant differing bit for early-exit timing.
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                             output logic [2:0] flags, output int lat);
        longint va, vb;
        logic [W-1:0] x;
        bit found;
        if (s) begin
            va = longint'($signed(a));
            vb = longint'($signed(b));
        end else begin
            va = longint'(a);
            vb = longint'(b);
        end
        flags = {va > vb, va < vb, va == vb};
        lat = W;
`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
        x = a ^ b;
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && x[i]) begin
                found = 1'b1;
                lat = W - i;
            end
        end
`else
        x = '0;
        found = 1'b0;
`endif
    endtask

    // Called #1 after a clock edge; returns #1 after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        int lat;
        logic [2:0] f;
        for (int k = 0; k < 4 * W && busy; k++) begin
            @(posedge clk); #1;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL accept_wait: busy stuck high (cycle %0d)", cyc);
        end
        ref_model(a, b, s, f, lat);
        e.flags    = f;
        e.done_cyc = cyc + 1 + lat;
        exp_q.push_back(e);
        last_flags = f;
        A = a;
        B = b;
        is_signed = s;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done never asserted (cycle %0d)", cyc);
            exp_q.delete();
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with nothing outstanding (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("flags", {A_gt_B, A_lt_B, A_eq_B}, e.flags);
                check("done_cycle", cyc, e.done_cyc);
                check("busy_at_done", busy, 1'b0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [W-1:0] ra, rb;
        int mode, gap;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_flags", {A_gt_B, A_lt_B, A_eq_B}, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        issue(8'hA5, 8'h5A, 1'b0); wait_done();
        issue(8'h3C, 8'h3C, 1'b0); wait_done();
        issue(8'h80, 8'h7F, 1'b1); wait_done();
        issue(8'h80, 8'h7F, 1'b0); wait_done();
        issue(8'h01, 8'h00, 1'b0); wait_done();
        issue(8'h7F, 8'h80, 1'b1); wait_done();
        issue(8'hFF, 8'h00, 1'b1); wait_done();

        // start while busy (sampled at T+3) must be ignored
        issue(8'h01, 8'h00, 1'b0);
        @(posedge clk); #1;
        A = 8'h00; B = 8'hFF; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        // back-to-back accept in the DONE cycle
        issue(8'h10, 8'h20, 1'b0); wait_done();

        // reset sampled at T+4 during a scan
        issue(8'h3C, 8'h3C, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_flags", {A_gt_B, A_lt_B, A_eq_B}, 3'b000);
        rst = 1'b0;
        repeat (2 * W) @(posedge clk);
        #1;
        issue(8'hA5, 8'h5A, 1'b0); wait_done();

        // Randomized compares with occasional idle gaps
        for (int t = 0; t < 200; t++) begin
            mode = int'($urandom_range(0, 3));
            ra = W'($urandom);
            rb = W'($urandom);
            if (mode == 0) rb = ra;
            else if (mode == 1) rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
            issue(ra, rb, 1'($urandom));
            wait_done();
            if ($urandom_range(0, 2) == 0) begin
                gap = int'($urandom_range(1, 3));
                repeat (gap) @(posedge clk);
                #1;
                check("held_flags", {A_gt_B, A_lt_B, A_eq_B}, last_flags);
            end
        end

        repeat (3 * W) @(posedge clk);
        #2;
        check("outstanding", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
